// File: rtl/image_window_buffer.sv
// ============================================================================
// Module   : image_window_buffer
// Purpose  : Frame-store 3x3 window generator (load full frame, then scan).
//            Define IMAGE_WIN_PAD_EN for zero-padded, centre-addressed windows.
// Revision : 1.0
// ============================================================================
`default_nettype none

module image_window_buffer #(
   parameter int PW    = 7,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [PW-1:0]            in_pixel,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [9*PW-1:0]          out_window,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col,
   output logic                     frame_done
);

   localparam int c_DEPTH = IMG_W * IMG_H;
   localparam int c_AW    = $clog2(c_DEPTH);
   localparam int c_RW    = $clog2(IMG_H);
   localparam int c_CW    = $clog2(IMG_W);

`ifdef IMAGE_WIN_PAD_EN
   localparam int c_PAD = 1;
`else
   localparam int c_PAD = 0;
`endif

   // Padded mode addresses windows by centre, so every pixel is a window origin
   localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'((c_PAD == 1) ? IMG_H - 1 : IMG_H - 3);
   localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'((c_PAD == 1) ? IMG_W - 1 : IMG_W - 3);
   localparam logic [c_AW-1:0] c_ADDR_LAST = c_AW'(c_DEPTH - 1);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_AW-1:0]   r_addr;
   logic [c_RW-1:0]   r_row;
   logic [c_CW-1:0]   r_col;
   logic              r_out_valid;
   logic              r_frame_done;
   logic [PW-1:0]     r_mem [0:c_DEPTH-1];

   logic [9*PW-1:0]   w_window;
   logic [c_AW-1:0]   w_idx;
   int                w_y;
   int                w_x;
   logic              w_load_fire;

   assign w_load_fire = (r_state == LOAD) && in_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= LOAD;
         r_addr       <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (in_valid) begin
                  if (r_addr == c_ADDR_LAST) begin
                     r_addr      <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= SCAN;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            SCAN: begin
               if (out_ready) begin
                  if (r_col == c_COL_LAST) begin
                     r_col <= '0;
                     if (r_row == c_ROW_LAST) begin
                        r_row        <= '0;
                        r_out_valid  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= DONE;
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            DONE: begin
               r_frame_done <= 1'b0;
               r_addr       <= '0;
               r_state      <= LOAD;
            end
            default: begin
               r_state      <= LOAD;
               r_addr       <= '0;
               r_row        <= '0;
               r_col        <= '0;
               r_out_valid  <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   // Frame store has no reset: an abandoned frame is simply overwritten
   always_ff @(posedge clk) begin
      if (w_load_fire) begin
         r_mem[r_addr] <= in_pixel;
      end
   end

   always_comb begin
      w_window = '0;
      w_y      = 0;
      w_x      = 0;
      w_idx    = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_y   = int'(r_row) + r - c_PAD;
            w_x   = int'(r_col) + c - c_PAD;
            w_idx = c_AW'(w_y * IMG_W + w_x);
            if (w_y >= 0 && w_y < IMG_H && w_x >= 0 && w_x < IMG_W) begin
               w_window[(3*r+c)*PW +: PW] = r_mem[w_idx];
            end
         end
      end
   end

   assign in_ready   = (r_state == LOAD);
   assign out_valid  = r_out_valid;
   assign out_window = w_window;
   assign out_row    = r_row;
   assign out_col    = r_col;
   assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_image_window_buffer.sv
// ============================================================================
// Module   : tb_image_window_buffer
// Purpose  : Directed bench for image_window_buffer (PW=8, 4x4 image).
//            Expectations follow IMAGE_WIN_PAD_EN when it is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_image_window_buffer;

   localparam int PW    = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
`ifdef IMAGE_WIN_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif
   localparam int NR = (PAD == 1) ? IMG_H : IMG_H - 2;
   localparam int NC = (PAD == 1) ? IMG_W : IMG_W - 2;
   localparam int NW = NR * NC;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [PW-1:0]   in_pixel;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [9*PW-1:0] out_window;
   logic [1:0]      out_row;
   logic [1:0]      out_col;
   logic            frame_done;

   int n_pass  = 0;
   int n_total = 0;

   image_window_buffer #(.PW(PW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_pixel   (in_pixel),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_row    (out_row),
      .out_col    (out_col),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Frame pixel k is (base + k) mod 256; out-of-image elements read as zero
   function automatic logic [9*PW-1:0] exp_win(input int base, input int row, input int col);
      logic [9*PW-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            int y;
            int x;
            y = row + r - PAD;
            x = col + c - PAD;
            if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
               w[(3*r+c)*PW +: PW] = PW'(base + y*IMG_W + x);
         end
      end
      return w;
   endfunction

   function automatic logic [9*PW-1:0] pack9(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
      logic [9*PW-1:0] w;
      w[0*PW +: PW] = PW'(a0); w[1*PW +: PW] = PW'(a1); w[2*PW +: PW] = PW'(a2);
      w[3*PW +: PW] = PW'(a3); w[4*PW +: PW] = PW'(a4); w[5*PW +: PW] = PW'(a5);
      w[6*PW +: PW] = PW'(a6); w[7*PW +: PW] = PW'(a7); w[8*PW +: PW] = PW'(a8);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int base, input bit gappy, input string tag);
      for (int k = 0; k < IMG_W*IMG_H; k++) begin
         if (gappy && k > 0) begin
            in_valid = 1'b0;
            in_pixel = 8'hAA;
            tick();
         end
         in_valid = 1'b1;
         in_pixel = PW'(base + k);
         n_total++;
         if (in_ready !== 1'b1) $display("FAIL %s in_ready_load k=%0d got=%b want=1", tag, k, in_ready);
         else n_pass++;
         n_total++;
         if (out_valid !== 1'b0) $display("FAIL %s out_valid_load k=%0d got=%b want=0", tag, k, out_valid);
         else n_pass++;
         tick();
      end
      in_valid = 1'b0;
      in_pixel = '0;
      n_total++;
      if (out_valid !== 1'b1 || out_row !== 2'd0 || out_col !== 2'd0)
         $display("FAIL %s first_window_latency got v=%b r=%0d c=%0d want v=1 r=0 c=0",
                  tag, out_valid, out_row, out_col);
      else n_pass++;
   endtask

   // Drives garbage on in_valid during the scan to prove it is ignored
   task automatic drain_frame(input int base, input int stall_idx, input string tag);
      logic [9*PW-1:0] ew;
      int er;
      int ec;
      in_valid  = 1'b1;
      in_pixel  = 8'hEE;
      out_ready = 1'b1;
      for (int i = 0; i < NW; i++) begin
         er = i / NC;
         ec = i % NC;
         ew = exp_win(base, er, ec);
         n_total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL %s scan_ctrl i=%0d got v=%b rdy=%b fd=%b want v=1 rdy=0 fd=0",
                     tag, i, out_valid, in_ready, frame_done);
         else n_pass++;
         n_total++;
         if (out_row !== 2'(er) || out_col !== 2'(ec))
            $display("FAIL %s coord i=%0d got (%0d,%0d) want (%0d,%0d)", tag, i, out_row, out_col, er, ec);
         else n_pass++;
         n_total++;
         if (out_window !== ew)
            $display("FAIL %s window i=%0d got=%h want=%h", tag, i, out_window, ew);
         else n_pass++;
         if (base == 0) begin
`ifdef IMAGE_WIN_PAD_EN
            if (i == 0) begin
               n_total++;
               if (out_window !== pack9(0,0,0,0,0,1,0,4,5))
                  $display("FAIL %s pad_win00 got=%h want=%h", tag, out_window, pack9(0,0,0,0,0,1,0,4,5));
               else n_pass++;
            end
            if (i == 15) begin
               n_total++;
               if (out_window !== pack9(10,11,0,14,15,0,0,0,0))
                  $display("FAIL %s pad_win33 got=%h want=%h", tag, out_window, pack9(10,11,0,14,15,0,0,0,0));
               else n_pass++;
            end
`else
            if (i == 0) begin
               n_total++;
               if (out_window !== pack9(0,1,2,4,5,6,8,9,10))
                  $display("FAIL %s win00 got=%h want=%h", tag, out_window, pack9(0,1,2,4,5,6,8,9,10));
               else n_pass++;
            end
            if (i == 3) begin
               n_total++;
               if (out_window !== pack9(5,6,7,9,10,11,13,14,15))
                  $display("FAIL %s win11 got=%h want=%h", tag, out_window, pack9(5,6,7,9,10,11,13,14,15));
               else n_pass++;
            end
`endif
         end
         if (i == stall_idx) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               n_total++;
               if (out_valid !== 1'b1 || out_row !== 2'(er) || out_col !== 2'(ec) || out_window !== ew)
                  $display("FAIL %s stall_hold s=%0d got v=%b (%0d,%0d) %h want v=1 (%0d,%0d) %h",
                           tag, s, out_valid, out_row, out_col, out_window, er, ec, ew);
               else n_pass++;
            end
            out_ready = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      in_pixel = '0;
      n_total++;
      if (frame_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL %s done_state got fd=%b v=%b rdy=%b want fd=1 v=0 rdy=0",
                  tag, frame_done, out_valid, in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (frame_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL %s back_to_load got fd=%b v=%b rdy=%b want fd=0 v=0 rdy=1",
                  tag, frame_done, out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_pixel  = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      n_total++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 2'd0 || out_col !== 2'd0)
         $display("FAIL reset_outputs got v=%b fd=%b r=%0d c=%0d want 0 0 0 0",
                  out_valid, frame_done, out_row, out_col);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
      else n_pass++;
   endtask

   task automatic test_stream();
      load_frame(0, 1'b0, "stream");
      drain_frame(0, -1, "stream");
   endtask

   task automatic test_backpressure();
      load_frame(0, 1'b0, "stall");
      drain_frame(0, 1, "stall");
   endtask

   task automatic test_gapped_load();
      load_frame(40, 1'b1, "gapped");
      drain_frame(40, -1, "gapped");
   endtask

   task automatic test_reset_midframe();
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1;
         in_pixel = PW'(50 + k);
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL midreset_async got v=%b fd=%b rdy=%b want 0 0 1", out_valid, frame_done, in_ready);
      else n_pass++;
      tick();
      rst = 1'b1;
      tick();
      load_frame(100, 1'b0, "midreset");
      drain_frame(100, -1, "midreset");
   endtask

   task automatic test_back_to_back();
      load_frame(200, 1'b0, "b2b_a");
      drain_frame(200, -1, "b2b_a");
      load_frame(7, 1'b0, "b2b_b");
      drain_frame(7, 2, "b2b_b");
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_gapped_load();
      test_reset_midframe();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/image_window_buffer.md
IMAGE_WINDOW_BUFFER -- requirements
Module: image_window_buffer

Interface
REQ-001 The block SHALL have parameter PW, default 7, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 28, image width in pixels (>=3).
REQ-003 The block SHALL have parameter IMG_H, default 28, image height in pixels (>=3).
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid  input  1  in_pixel is valid.
REQ-007 The block SHALL have port in_pixel  input  PW  pixel, raster order, row 0 first.
REQ-008 The block SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-009 The block SHALL have port out_valid  output  1  out_window is valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the window.
REQ-011 The block SHALL have port out_window  output  9*PW  3x3 window; element (r,c) at bits [(3r+c)*PW +: PW], (0,0) is top-left.
REQ-012 The block SHALL have ports out_row and out_col  output  clog2(IMG_H) and clog2(IMG_W)  window coordinate.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle pulse after the last window of a frame.

Function
REQ-014 The block SHALL hold an IMG_W*IMG_H x PW register array as frame store.
REQ-015 The FSM SHALL have states LOAD, SCAN and DONE.
REQ-016 In LOAD, in_ready SHALL be 1; each in_valid&in_ready cycle SHALL write mem[addr] and increment addr.
REQ-017 On acceptance of pixel IMG_W*IMG_H-1, the FSM SHALL go to SCAN and out_valid SHALL be 1 the next cycle (1-cycle latency).
REQ-018 In SCAN and DONE, in_ready SHALL be 0; in_valid SHALL be ignored.
REQ-019 In SCAN, out_valid SHALL be 1 and out_window SHALL be derived combinationally from the registered (out_row,out_col).
REQ-020 On out_valid&out_ready, out_col SHALL increment; at its last value it SHALL wrap to 0 and out_row SHALL increment.
REQ-021 While out_valid&!out_ready, out_window, out_row and out_col SHALL hold stable.
REQ-022 On acceptance of the last window, the FSM SHALL go to DONE; in DONE, frame_done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to LOAD with addr=0.
REQ-023 Windows SHALL be emitted strictly in raster order, with no skipped or repeated coordinates.
REQ-024 Frame store contents SHALL NOT be modified outside LOAD.

Reset
REQ-025 Asserting rst low SHALL immediately force state LOAD, addr=0, out_row=0, out_col=0, out_valid=0, frame_done=0, with in_ready=1 after rst releases.
REQ-026 Reset mid-LOAD or mid-SCAN SHALL abandon the frame; the frame store need not be cleared.
REQ-027 The first frame after reset release SHALL load from addr 0.

Configuration
REQ-028 Macro IMAGE_WIN_PAD_EN SHALL select zero-padded mode.
REQ-029 Without IMAGE_WIN_PAD_EN, out_row/out_col SHALL be the window's top-left coordinate, ranging 0..IMG_H-3 and 0..IMG_W-3, giving (IMG_W-2)*(IMG_H-2) windows (676 at defaults).
REQ-030 With IMAGE_WIN_PAD_EN, out_row/out_col SHALL be the window's centre coordinate, ranging 0..IMG_H-1 and 0..IMG_W-1, giving IMG_W*IMG_H windows (784 at defaults), with out-of-image elements set to 0.

Verification (PW=8, IMG_W=IMG_H=4, pixel k = k)
REQ-031 The bench SHALL check: no macro, stream 0..15, out_ready=1 -> out_valid the cycle after pixel 15; 4 windows; (0,0) = {0,1,2,4,5,6,8,9,10}; (1,1) = {5,6,7,9,10,11,13,14,15}; one frame_done pulse.
REQ-032 The bench SHALL check: IMAGE_WIN_PAD_EN, same stream -> 16 windows; (0,0) = {0,0,0,0,0,1,0,4,5}; (3,3) = {10,11,0,14,15,0,0,0,0}.
REQ-033 The bench SHALL check: out_ready low 5 cycles at window (0,1) -> outputs stable; no window lost or duplicated.
REQ-034 The bench SHALL check: in_valid toggled every other cycle in LOAD -> stored data identical; in_ready=0 throughout SCAN.
REQ-035 The bench SHALL check: rst low after 7 pixels, release, stream a fresh 16 pixels -> correct windows from the new frame only.
REQ-036 The bench SHALL check: two back-to-back frames -> second frame loads after frame_done, with addr restarting at 0.
